// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF array: FSM state encoding,
// width helpers and the challenge rotation used to diversify the chains.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int MAX_N = 64;

  function automatic int vote_w(input int reps);
    return $clog2(reps + 1);
  endfunction

  function automatic int rep_w(input int reps);
    return (reps > 1) ? $clog2(reps) : 1;
  endfunction

  function automatic int settle_w(input int settle);
    return $clog2(settle + 3);
  endfunction

  // Rotate the low n bits of v left by k; bits above n stay zero.
  function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] v, input int n, input int k);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[6'((i + k) % n)] = v[6'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/puf_chain.sv
// One arbiter-PUF delay chain: N crossover stages, a race arbiter cleared while
// launch is low, and a 2-flop synchroniser bringing the decision into clk.
module puf_chain #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_launch,
  input  logic [N-1:0] i_chal,
  output logic         o_sync
);

  logic w_upper;
  logic w_lower;
  logic r_arb;
  logic r_sync1;
  logic r_sync2;

  // Each stage either passes both paths straight through or swaps them.
  always_comb begin
    logic v_top;
    logic v_bot;
    v_top = i_launch;
    v_bot = i_launch;
    for (int i = 0; i < N; i++) begin
      if (i_chal[i]) {v_top, v_bot} = {v_bot, v_top};
    end
    w_upper = v_top;
    w_lower = v_bot;
  end

  always_ff @(posedge w_lower or negedge i_launch) begin
    if (!i_launch) r_arb <= 1'b0;
    else           r_arb <= w_upper;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= r_arb;
      r_sync2 <= r_sync1;
    end
  end

  assign o_sync = r_sync2;

endmodule

// File: rtl/puf_array_ctrl.sv
// Arbiter-PUF engine: accepts a challenge, runs REPS clear/launch/sample rounds
// over CHAINS chains and returns majority-voted bits with per-bit stability.
module puf_array_ctrl
  import puf_pkg::*;
#(
  parameter int N      = 8,
  parameter int CHAINS = 4,
  parameter int SETTLE = 16,
  parameter int REPS   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      challenge,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic [CHAINS-1:0] response,
  output logic [CHAINS-1:0] stable,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy
);

  localparam int VW = vote_w(REPS);
  localparam int RW = rep_w(REPS);
  localparam int CW = settle_w(SETTLE);

  if (REPS < 1 || (REPS % 2) == 0) begin : g_bad_reps
    $error("puf_array_ctrl: REPS must be odd and >= 1");
  end
  if (N < 2 || N > MAX_N || CHAINS < 1 || SETTLE < 1) begin : g_bad_dims
    $error("puf_array_ctrl: N, CHAINS or SETTLE out of range");
  end

  state_e            r_state;
  logic [N-1:0]      r_chal;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_rep;
  logic [VW-1:0]     r_vote [CHAINS];
  logic              r_launch;
  logic [CHAINS-1:0] r_response;
  logic [CHAINS-1:0] r_stable;
  logic              r_resp_valid;
  logic              r_chal_ready;
  logic              r_busy;

  logic [CHAINS-1:0] w_sync;
  logic [VW-1:0]     w_vote_nxt [CHAINS];
  logic [CHAINS-1:0] w_resp_nxt;
  logic [CHAINS-1:0] w_stab_nxt;

  for (genvar k = 0; k < CHAINS; k++) begin : g_chain
    logic [N-1:0] w_sel;
    assign w_sel = N'(rotl(MAX_N'(r_chal), N, k));
    puf_chain #(.N(N)) u_chain (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_launch (r_launch),
      .i_chal   (w_sel),
      .o_sync   (w_sync[k])
    );
  end

  // Votes including the bit sampled this cycle, so the last round can be
  // folded straight into the registered response.
  always_comb begin
    w_resp_nxt = '0;
    w_stab_nxt = '0;
    for (int k = 0; k < CHAINS; k++) begin
      w_vote_nxt[k] = r_vote[k] + VW'(w_sync[k]);
      w_resp_nxt[k] = (w_vote_nxt[k] > VW'(REPS / 2));
      w_stab_nxt[k] = (w_vote_nxt[k] == '0) || (w_vote_nxt[k] == VW'(REPS));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_chal       <= '0;
      r_cnt        <= '0;
      r_rep        <= '0;
      for (int k = 0; k < CHAINS; k++) r_vote[k] <= '0;
      r_launch     <= 1'b0;
      r_response   <= '0;
      r_stable     <= '0;
      r_resp_valid <= 1'b0;
      r_chal_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_chal_ready <= 1'b1;
          if (chal_valid && r_chal_ready) begin
            r_chal       <= challenge;
            r_cnt        <= '0;
            r_rep        <= '0;
            for (int k = 0; k < CHAINS; k++) r_vote[k] <= '0;
            r_chal_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == CW'(SETTLE - 1)) begin
            r_cnt    <= '0;
            r_launch <= 1'b1;
            r_state  <= ST_LAUNCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LAUNCH: begin
          // Two extra cycles let the arbiter decision cross the synchroniser.
          if (r_cnt == CW'(SETTLE + 1)) begin
            r_cnt    <= '0;
            r_launch <= 1'b0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          for (int k = 0; k < CHAINS; k++) r_vote[k] <= w_vote_nxt[k];
          if (r_rep == RW'(REPS - 1)) begin
            r_response   <= w_resp_nxt;
            r_stable     <= w_stab_nxt;
            r_resp_valid <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_rep   <= r_rep + 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_chal_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign chal_ready = r_chal_ready;
  assign response   = r_response;
  assign stable     = r_stable;
  assign resp_valid = r_resp_valid;
  assign busy       = r_busy;

endmodule
